// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Held at the widest supported width; users slice down to DATA_WIDTH.
  localparam int unsigned       MAX_WIDTH     = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;
  localparam logic [MAX_WIDTH-1:0] MIN_SIGNED    = {1'b1, {(MAX_WIDTH - 1){1'b0}}};

  function automatic logic is_div_op(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  no_borrow;

  // Top bit of the extra-wide difference is the borrow out of the trial subtract.
  assign shifted   = {rem_i, quo_i[DATA_WIDTH-1]};
  assign diff      = shifted - {2'b00, divisor_i};
  assign no_borrow = ~diff[DATA_WIDTH+1];

  assign rem_o = no_borrow ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
  assign quo_o = {quo_i[DATA_WIDTH-2:0], no_borrow};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 RV32M divider beside the ALU; stalls the pipe until the result is ready.
// Define MULDIV_MUL_EN to add the shift-add multiplier for funct3 000-011.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] AllOnes = DIV0_QUOTIENT[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MinNeg  = MIN_SIGNED[MAX_WIDTH-1 -: DATA_WIDTH];

  state_t                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dsr_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;

  // Operand decode for the accepting cycle.
  logic                  a_signed, b_signed, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  div_op, div_zero, div_ovf, fast_done;

  assign a_signed = (op_i == OP_DIV) || (op_i == OP_REM) || (op_i == OP_MULH) ||
                    (op_i == OP_MULHSU);
  assign b_signed = (op_i == OP_DIV) || (op_i == OP_REM) || (op_i == OP_MULH);
  assign a_neg    = a_signed & srcA_i[DATA_WIDTH-1];
  assign b_neg    = b_signed & srcB_i[DATA_WIDTH-1];
  assign a_mag    = a_neg ? -srcA_i : srcA_i;
  assign b_mag    = b_neg ? -srcB_i : srcB_i;
  assign div_op   = is_div_op(op_i);
  assign div_zero = div_op & (srcB_i == '0);
  assign div_ovf  = div_op & ~op_i[0] & (srcA_i == MinNeg) & (srcB_i == AllOnes);

`ifdef MULDIV_MUL_EN
  assign fast_done = div_zero | div_ovf;
`else
  assign fast_done = div_zero | div_ovf | ~div_op;
`endif

  // Per-cycle datapath step.
  logic [DATA_WIDTH:0]   div_rem, step_rem;
  logic [DATA_WIDTH-1:0] div_quo, step_quo;

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dsr_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

`ifdef MULDIV_MUL_EN
  // Shift-add: high half lives in rem_q, multiplier drains out of quo_q's LSB.
  logic [DATA_WIDTH:0] mul_sum;
  assign mul_sum  = {1'b0, rem_q[DATA_WIDTH-1:0]} + (quo_q[0] ? {1'b0, dsr_q} : '0);
  assign step_rem = is_div_op(op_q) ? div_rem : {1'b0, mul_sum[DATA_WIDTH:1]};
  assign step_quo = is_div_op(op_q) ? div_quo : {mul_sum[0], quo_q[DATA_WIDTH-1:1]};
`else
  assign step_rem = div_rem;
  assign step_quo = div_quo;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q <= op_i;
            if (fast_done) begin
              state_q   <= DONE;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              dsr_q     <= '0;
              quo_q     <= div_zero ? AllOnes : (div_ovf ? MinNeg : '0);
              rem_q     <= div_zero ? {1'b0, srcA_i} : '0;
            end else begin
              state_q   <= CALC;
              cnt_q     <= CntW'(DATA_WIDTH);
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              rem_q     <= '0;
              quo_q     <= div_op ? a_mag : b_mag;
              dsr_q     <= div_op ? b_mag : a_mag;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sign fix-up on the latched magnitudes, only observed in DONE.
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];

`ifdef MULDIV_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;
  assign prod     = {rem_q[DATA_WIDTH-1:0], quo_q};
  assign prod_fix = neg_quo_q ? -prod : prod;
`endif

  always_comb begin
    result_o = '0;
    if (state_q == DONE) begin
      unique case (op_q)
        OP_DIV, OP_DIVU: result_o = quo_fix;
        OP_REM, OP_REMU: result_o = rem_fix;
`ifdef MULDIV_MUL_EN
        OP_MUL:                       result_o = prod_fix[DATA_WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
`else
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: result_o = '0;
`endif
        default: result_o = '0;
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign stall_o = rst_ni & start_i & (state_q != DONE) & ~flush_i;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: transaction-level reference model plus directed and random stimulus.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_ni, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start),
    .op_i     (op),
    .srcA_i   (a),
    .srcB_i   (b),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = computing (m_left edges to go), 2 = result showing.
  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;

  logic        last_stall, last_busy, last_done;
  logic [31:0] last_res;

  function automatic bit is_div(logic [2:0] o);
    return o[2];
  endfunction

  function automatic bit quick(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    if (is_div(o))
      return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef MULDIV_MUL_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] ref_result(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    logic signed [31:0] sq;
    logic [63:0] sx, sy, zx, zy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    zx = {32'd0, x};
    zy = {32'd0, y};
    p  = 64'd0;
    case (o)
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b111: return (y == 0) ? x : x % y;
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = $signed(x) / $signed(y);
        return sq;
      end
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        sq = $signed(x) % $signed(y);
        return sq;
      end
`ifdef MULDIV_MUL_EN
      3'b000: begin p = zx * zy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * zy; return p[63:32]; end
      default: begin p = zx * zy; return p[63:32]; end
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare at negedge, then advance the model on the posedge.
  task automatic step();
    @(negedge clk);
    last_stall = stall;
    last_busy  = busy;
    last_done  = done;
    last_res   = result;
    chk1("busy", busy, m_mode != 0);
    chk1("done", done, m_mode == 2);
    chk1("stall", stall, start && (m_mode != 2) && !flush && rst_ni);
    if (m_mode == 2) chk("result", result, m_res);
    @(posedge clk);
    if (!rst_ni || flush) m_mode = 0;
    else begin
      case (m_mode)
        0: if (start) begin
          m_res = ref_result(op, a, b);
          if (quick(op, a, b)) m_mode = 2;
          else begin
            m_mode = 1;
            m_left = W;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic run_op(string name, logic [2:0] o, logic [31:0] x, logic [31:0] y,
                        logic [31:0] exp_res, int exp_lat);
    int          stalls = 0;
    int          lat = -1;
    bit          got = 0;
    logic        first_busy = 1'b1;
    logic [31:0] r = '0;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      if (c == 0) first_busy = last_busy;
      if (last_stall) stalls++;
      if (last_done) begin
        got = 1;
        lat = c;
        r   = last_res;
      end
    end
    if (!got) $display("FAIL %s: no done within 100 cycles", name);
    chk({name, " result"}, r, exp_res);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " stall cycles"}, stalls, exp_lat);
    chk1({name, " idle at accept"}, first_busy, 1'b0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_ni = 1'b0;
    start  = 1'b1;
    flush  = 1'b0;
    op     = 3'b101;
    a      = 32'd0;
    b      = 32'd0;
    #2;
    chk1("reset stall", stall, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk("reset result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b0;
    rst_ni = 1'b1;
    step();

    run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    start = 1'b0; step();
    run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    start = 1'b0; step();
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    start = 1'b0; step();
    run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    start = 1'b0; step();
    run_op("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    start = 1'b0; step();
    run_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    start = 1'b0; step();
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    start = 1'b0; step();
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    start = 1'b0; step();
`ifdef MULDIV_MUL_EN
    run_op("mulh -3*5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 33);
`else
    run_op("mul disabled", 3'b000, 32'd3, 32'd5, 32'd0, 1);
`endif
    start = 1'b0; step();

    // Flush at cycle 10 of a long divide, then restart.
    start = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd3;
    repeat (10) step();
    flush = 1'b1;
    step();
    chk1("flush cycle stall", last_stall, 1'b0);
    flush = 1'b0;
    start = 1'b0;
    step();
    chk1("post-flush busy", last_busy, 1'b0);
    chk1("post-flush done", last_done, 1'b0);
    run_op("divu 9/3 after flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    start = 1'b0; step();

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    repeat (5) step();
    rst_ni = 1'b0;
    m_mode = 0;
    #1;
    chk1("midop reset stall", stall, 1'b0);
    chk1("midop reset busy", busy, 1'b0);
    chk1("midop reset done", done, 1'b0);
    step();
    start  = 1'b0;
    rst_ni = 1'b1;
    step();

    // Back-to-back with start held throughout.
    run_op("b2b divu 8/2", 3'b101, 32'd8, 32'd2, 32'd4, 33);
    run_op("b2b divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    start = 1'b0; step();

    // Random traffic; operands change freely while busy and must be ignored.
    for (int i = 0; i < 6000; i++) begin
      if (m_mode == 0 || $urandom_range(0, 3) == 0) begin
        op = 3'($urandom);
        a  = rnd_operand();
        b  = rnd_operand();
      end
      if (m_mode == 0) start = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
